intra_pred_gen: RTL and testbench

Parametrised intra-prediction generator. It produces one full BLOCK_SIZE x BLOCK_SIZE prediction block from the top, left and top-left neighbour samples, in one of four modes: DC, TrueMotion (TM), Vertical (VE) or Horizontal (HE). It replaces the DC-only predictor in the intra-mode search path. DC sums LANES samples per cycle, and the row modes write one row per cycle into a registered output array.

---
 rtl/intra_pred_gen.sv | 175 +++++++++++++++++
 tb/tb_intra_pred_gen.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/intra_pred_gen.sv
// Intra-prediction block generator: DC, TrueMotion, Vertical, Horizontal.
// One registered BLOCK_SIZE x BLOCK_SIZE output per accepted request.
module intra_pred_gen #(
  parameter int BIT_WIDTH  = 8,
  parameter int BLOCK_SIZE = 16,
  parameter int LOG2_SIZE  = 4,
  parameter int LANES      = 4,
  parameter int BLOCK_NUM  = 10
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   start,
  input  logic [1:0]                             mode,
  input  logic [BLOCK_NUM-1:0]                   x,
  input  logic [BLOCK_NUM-1:0]                   y,
  input  logic [BIT_WIDTH*BLOCK_SIZE-1:0]        top,
  input  logic [BIT_WIDTH*BLOCK_SIZE-1:0]        left,
  input  logic [BIT_WIDTH-1:0]                   top_left,
  output logic [BIT_WIDTH*BLOCK_SIZE*BLOCK_SIZE-1:0] dst,
  output logic                                   busy,
  output logic                                   done
);

  localparam int PW    = BIT_WIDTH * BLOCK_SIZE;
  localparam int DW    = PW * BLOCK_SIZE;
  localparam int AW    = BIT_WIDTH + LOG2_SIZE + 1;
  localparam int STEPS = BLOCK_SIZE / LANES;
  localparam logic [LOG2_SIZE-1:0] LAST_ACC = LOG2_SIZE'(STEPS - 1);
  localparam logic [BIT_WIDTH-1:0] MID =
    {1'b1, {(BIT_WIDTH-1){1'b0}}};
  localparam logic [BIT_WIDTH-1:0] V0 =
    {1'b0, {(BIT_WIDTH-1){1'b1}}};
  localparam logic [BIT_WIDTH-1:0] H0 =
    {1'b1, {(BIT_WIDTH-2){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    IDLE, ACC, FILL, ROW, DONE
  } state_t;

  state_t                 state_q, state_d;
  logic                   pend_q, pend_d;
  logic [LOG2_SIZE-1:0]   cnt_q, cnt_d;
  logic [AW-1:0]          acc_q, acc_d;
  logic [DW-1:0]          dst_q, dst_d;
  logic [1:0]             mode_q;
  logic                   l_q, t_q;
  logic [PW-1:0]          top_q, left_q;
  logic [BIT_WIDTH-1:0]   tl_q;

  logic                   accept;
  logic [AW-1:0]          add, rnd;
  logic [BIT_WIDTH-1:0]   fill_v;
  logic [PW-1:0]          row_v;
  logic                   is_tm, tm_both, use_ve, use_he;

  assign accept  = (state_q == IDLE) && !pend_q && start;
  assign is_tm   = (mode_q == 2'd1);
  assign tm_both = is_tm && l_q && t_q;
  assign use_ve  = (mode_q == 2'd2) || (is_tm && t_q && !l_q);
  assign use_he  = (mode_q == 2'd3) || (is_tm && l_q && !t_q);

  always_comb begin : dp
    logic [AW-1:0]          st, sl;
    logic [LOG2_SIZE-1:0]   idx;
    logic [BIT_WIDTH-1:0]   tp, lf;
    logic [BIT_WIDTH+1:0]   tm;
    st = '0;
    sl = '0;
    for (int i = 0; i < LANES; i++) begin
      idx = LOG2_SIZE'(int'(cnt_q) * LANES + i);
      st  = st + AW'(top_q[BIT_WIDTH*int'(idx) +: BIT_WIDTH]);
      sl  = sl + AW'(left_q[BIT_WIDTH*int'(idx) +: BIT_WIDTH]);
    end
    case ({t_q, l_q})
      2'b11:   add = st + sl;
      2'b10:   add = st << 1;
      2'b01:   add = sl << 1;
      default: add = '0;
    endcase
    rnd    = acc_q + AW'(BLOCK_SIZE);
    fill_v = (t_q || l_q) ? rnd[AW-1 -: BIT_WIDTH] : MID;
    lf     = left_q[BIT_WIDTH*int'(cnt_q) +: BIT_WIDTH];
    row_v  = '0;
    for (int c = 0; c < BLOCK_SIZE; c++) begin
      tp = top_q[BIT_WIDTH*c +: BIT_WIDTH];
      // two's complement: top two bits flag under/overflow
      tm = {2'b00, tp} + {2'b00, lf} - {2'b00, tl_q};
      unique case (1'b1)
        tm_both: row_v[BIT_WIDTH*c +: BIT_WIDTH] =
                   tm[BIT_WIDTH+1] ? '0 :
                   tm[BIT_WIDTH]   ? '1 : tm[BIT_WIDTH-1:0];
        use_ve:  row_v[BIT_WIDTH*c +: BIT_WIDTH] = t_q ? tp : V0;
        use_he:  row_v[BIT_WIDTH*c +: BIT_WIDTH] = l_q ? lf : H0;
        default: row_v[BIT_WIDTH*c +: BIT_WIDTH] = MID;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    dst_d   = dst_q;
    unique case (state_q)
      IDLE: begin
        if (!pend_q) begin
          pend_d = start;
        end else begin
          cnt_d = '0;
          acc_d = '0;
          if (mode_q == 2'd0)
            state_d = (t_q || l_q) ? ACC : FILL;
          else
            state_d = ROW;
        end
      end
      ACC: begin
        acc_d = acc_q + add;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_ACC) state_d = FILL;
      end
      FILL: begin
        for (int i = 0; i < BLOCK_SIZE*BLOCK_SIZE; i++)
          dst_d[BIT_WIDTH*i +: BIT_WIDTH] = fill_v;
        state_d = DONE;
      end
      ROW: begin
        dst_d[PW*int'(cnt_q) +: PW] = row_v;
        cnt_d = cnt_q + 1'b1;
        if (&cnt_q) state_d = DONE;
      end
      DONE: begin
        pend_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pend_q  <= 1'b0;
      cnt_q   <= '0;
      acc_q   <= '0;
      dst_q   <= '0;
      mode_q  <= '0;
      l_q     <= 1'b0;
      t_q     <= 1'b0;
      top_q   <= '0;
      left_q  <= '0;
      tl_q    <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      dst_q   <= dst_d;
      if (accept) begin
        mode_q <= mode;
        l_q    <= |x;
        t_q    <= |y;
        top_q  <= top;
        left_q <= left;
        tl_q   <= top_left;
      end
    end
  end

  assign dst  = dst_q;
  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);

endmodule

// File: tb/tb_intra_pred_gen.sv
// Scoreboard bench for intra_pred_gen with hand-computed blocks.
// Stimulus pushes expectations; a negedge monitor checks each done.
module tb_intra_pred_gen;

  localparam int PW = 8 * 16;
  localparam int DW = PW * 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [1:0]    mode = '0;
  logic [9:0]    x = '0, y = '0;
  logic [PW-1:0] top = '0, left = '0;
  logic [7:0]    top_left = '0;
  logic [DW-1:0] dst;
  logic          busy, done;

  intra_pred_gen dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
    .x(x), .y(y), .top(top), .left(left), .top_left(top_left),
    .dst(dst), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] blk;
    int            lat;
    int            t0;
    string         name;
  } exp_t;

  exp_t sbq[$];
  exp_t me;
  int total = 0, bad = 0;
  int cyc = 0, bcnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] all_px(logic [7:0] v);
    logic [DW-1:0] r;
    for (int i = 0; i < 256; i++) r[8*i +: 8] = v;
    return r;
  endfunction

  function automatic logic [PW-1:0] edge_c(logic [7:0] v);
    logic [PW-1:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = v;
    return r;
  endfunction

  function automatic logic [PW-1:0] edge_ramp(int k);
    logic [PW-1:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = 8'(i * k);
    return r;
  endfunction

  task automatic check_blk(string nm, logic [DW-1:0] got,
                           logic [DW-1:0] want);
    int p;
    total++;
    if (got !== want) begin
      bad++;
      p = 0;
      for (int i = 255; i >= 0; i--)
        if (got[8*i +: 8] !== want[8*i +: 8]) p = i;
      $display("FAIL %s px(%0d,%0d) got %0d want %0d", nm,
               p / 16, p % 16, got[8*p +: 8], want[8*p +: 8]);
    end
  endtask

  task automatic check_val(string nm, int got, int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s got %0d want %0d", nm, got, want);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      bcnt = 0;
    end else begin
      if (busy) bcnt++;
      if (done) begin
        total++;
        if (sbq.size() == 0) begin
          bad++;
          $display("FAIL spurious_done got done=1 want no done");
        end else begin
          me = sbq.pop_front();
          check_blk(me.name, dst, me.blk);
          check_val({me.name, "_lat"}, cyc - me.t0 - 1, me.lat);
          check_val({me.name, "_busy"}, bcnt, me.lat);
        end
        bcnt = 0;
      end
    end
  end

  task automatic issue(logic [1:0] m, logic [9:0] xx, logic [9:0] yy,
                       logic [PW-1:0] t, logic [PW-1:0] l,
                       logic [7:0] tl, logic [DW-1:0] want,
                       int lat, string nm, bit push);
    exp_t e;
    @(negedge clk);
    mode = m; x = xx; y = yy;
    top = t; left = l; top_left = tl;
    start = 1'b1;
    if (push) begin
      e.blk = want; e.lat = lat; e.t0 = cyc; e.name = nm;
      sbq.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drain(string nm);
    for (int i = 0; i < 200 && sbq.size() != 0; i++) begin
      @(negedge clk);
      #1;
    end
    total++;
    if (sbq.size() != 0) begin
      bad++;
      $display("FAIL %s_timeout got pending=%0d want 0", nm, sbq.size());
      sbq.delete();
    end
  endtask

  logic [DW-1:0] w;

  initial begin
    repeat (3) @(negedge clk);
    check_blk("reset_dst", dst, '0);
    check_val("reset_busy", int'(busy), 0);
    check_val("reset_done", int'(done), 0);
    rst_n = 1'b1;
    @(negedge clk);

    issue(2'd0, 10'd1, 10'd1, edge_c(8'd10), edge_c(8'd20), 8'd0,
          all_px(8'd15), 6, "dc_both", 1'b1);
    drain("dc_both");

    issue(2'd0, 10'd0, 10'd3, edge_ramp(1), edge_c(8'd255), 8'd0,
          all_px(8'd8), 6, "dc_top", 1'b1);
    drain("dc_top");

    issue(2'd0, 10'd0, 10'd0, edge_c(8'd9), edge_c(8'd9), 8'd0,
          all_px(8'h80), 2, "dc_none", 1'b1);
    drain("dc_none");

    w = all_px(8'd200);
    for (int c = 0; c < 16; c++) begin
      w[8*c +: 8]      = 8'd250;
      w[8*(16+c) +: 8] = 8'd150;
    end
    left = edge_c(8'd50);
    left[7:0] = 8'd100;
    left[15:8] = 8'd0;
    issue(2'd1, 10'd1, 10'd1, edge_c(8'd200), left, 8'd50,
          w, 17, "tm_rows", 1'b1);
    drain("tm_rows");

    issue(2'd1, 10'd1, 10'd1, edge_c(8'd250), edge_c(8'd250), 8'd0,
          all_px(8'd255), 17, "tm_clip_hi", 1'b1);
    drain("tm_clip_hi");

    issue(2'd1, 10'd1, 10'd1, edge_c(8'd0), edge_c(8'd0), 8'd200,
          all_px(8'd0), 17, "tm_clip_lo", 1'b1);
    drain("tm_clip_lo");

    issue(2'd2, 10'd4, 10'd0, edge_ramp(2), edge_c(8'd1), 8'd0,
          all_px(8'h7F), 17, "ve_none", 1'b1);
    drain("ve_none");

    issue(2'd3, 10'd0, 10'd4, edge_ramp(2), edge_c(8'd1), 8'd0,
          all_px(8'h81), 17, "he_none", 1'b1);
    drain("he_none");

    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++) w[8*(16*r+c) +: 8] = 8'(r);
    issue(2'd3, 10'd1, 10'd0, edge_c(8'd99), edge_ramp(1), 8'd0,
          w, 17, "he_ramp", 1'b1);
    drain("he_ramp");

    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++) w[8*(16*r+c) +: 8] = 8'(3 * c);
    issue(2'd1, 10'd0, 10'd2, edge_ramp(3), edge_c(8'd77), 8'd5,
          w, 17, "tm_as_ve", 1'b1);
    drain("tm_as_ve");

    issue(2'd0, 10'd1, 10'd1, edge_c(8'd10), edge_c(8'd20), 8'd0,
          all_px(8'd15), 6, "dc_ignore", 1'b1);
    top = edge_c(8'd0);
    @(negedge clk);
    mode = 2'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drain("dc_ignore");
    repeat (25) @(negedge clk);

    issue(2'd0, 10'd1, 10'd1, edge_c(8'd10), edge_c(8'd20), 8'd0,
          all_px(8'd15), 6, "b2b_a", 1'b1);
    drain("b2b_a");
    issue(2'd2, 10'd0, 10'd1, edge_c(8'd33), edge_c(8'd0), 8'd0,
          all_px(8'd33), 17, "b2b_b", 1'b1);
    drain("b2b_b");

    issue(2'd2, 10'd0, 10'd1, edge_ramp(1), edge_c(8'd0), 8'd0,
          '0, 0, "rst_row", 1'b0);
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_blk("rst_mid_dst", dst, '0);
    check_val("rst_mid_busy", int'(busy), 0);
    check_val("rst_mid_done", int'(done), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (25) @(negedge clk);

    issue(2'd0, 10'd1, 10'd1, edge_c(8'd10), edge_c(8'd20), 8'd0,
          all_px(8'd15), 6, "dc_after_rst", 1'b1);
    drain("dc_after_rst");
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
